// File: rtl/barramento_memoria.sv
// Memory/IO subsystem: word RAM, LED and HEX output registers, and a loader FSM
// that fills RAM from a word stream before enabling the processor via run.
module barramento_memoria #(
    parameter int          ADDR_BITS = 7,
    parameter logic [3:0]  LED_BASE  = 4'h1,
    parameter logic [3:0]  HEX_BASE  = 4'h2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] daddr,
    input  logic [15:0] dout,
    input  logic        w,
    output logic [15:0] din,
    output logic        run,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [15:0] leds,
    output logic [15:0] hex,
    output logic        err
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {CARGA, EXEC} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [15:0]            din_q, din_d;
    logic [15:0]            leds_q, leds_d;
    logic [15:0]            hex_q, hex_d;
    logic                   err_q, err_d;

    logic [15:0]            mem [DEPTH];
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [15:0]            mem_wdata;

    logic [3:0]             region;
    logic [ADDR_BITS-1:0]   idx;
    logic                   sel_ram, sel_led, sel_hex, unmapped;
    logic                   accept, ptr_full;
    logic                   unused_daddr;

    assign region   = daddr[15:12];
    assign idx      = daddr[ADDR_BITS-1:0];
    assign sel_ram  = (region == 4'h0);
    assign sel_led  = (region == LED_BASE);
    assign sel_hex  = (region == HEX_BASE);
    assign unmapped = !(sel_ram || sel_led || sel_hex);
    assign accept   = load_valid && load_ready;
    assign ptr_full = (ptr_q == ADDR_BITS'(DEPTH - 1));
    // Index bits between the RAM index and the region field alias onto RAM.
    assign unused_daddr = ^daddr[11:ADDR_BITS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= CARGA;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CARGA && accept && (load_last || ptr_full))
            state_d = EXEC;
    end

    always_comb begin
        run        = (state_q == EXEC);
        load_ready = (state_q == CARGA);
    end

    always_comb begin
        ptr_d     = ptr_q;
        din_d     = 16'h0000;
        leds_d    = leds_q;
        hex_d     = hex_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = load_data;
        if (state_q == CARGA) begin
            if (accept) begin
                mem_we = 1'b1;
                if (!ptr_full) ptr_d = ptr_q + ADDR_BITS'(1);
            end
        end else begin
            // Reads use pre-edge contents, so read-during-write returns the old value.
            if (sel_ram)      din_d = mem[idx];
            else if (sel_led) din_d = leds_q;
            else if (sel_hex) din_d = hex_q;
            if (unmapped) err_d = 1'b1;
            if (w) begin
                if (sel_ram) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx;
                    mem_wdata = dout;
                end
                if (sel_led) leds_d = dout;
                if (sel_hex) hex_d  = dout;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            din_q  <= 16'h0000;
            leds_q <= 16'h0000;
            hex_q  <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            din_q  <= din_d;
            leds_q <= leds_d;
            hex_q  <= hex_d;
            err_q  <= err_d;
        end
    end

    // RAM survives reset so a reload only overwrites the words it covers.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign din  = din_q;
    assign leds = leds_q;
    assign hex  = hex_q;
    assign err  = err_q;
endmodule

// File: tb/tb_barramento_memoria.sv
// Bench for barramento_memoria: directed steps plus random EXEC traffic checked
// every cycle against a behavioural model of the memory map and loader.
module tb_barramento_memoria;
    localparam int DEPTH = 128;

    logic        clock, reset;
    logic [15:0] daddr, dout, din, load_data, leds, hex;
    logic        w, run, load_valid, load_last, load_ready, err;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_mem [DEPTH];
    int          m_ptr;
    bit          m_run, m_err;
    logic [15:0] m_din, m_leds, m_hex;
    logic [15:0] first_word, pre_word;

    barramento_memoria dut (
        .clock(clock), .reset(reset), .daddr(daddr), .dout(dout), .w(w),
        .din(din), .run(run), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .leds(leds), .hex(hex),
        .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_run = 0; m_err = 0;
        m_din = 16'h0; m_leds = 16'h0; m_hex = 16'h0;
    endtask

    // One clock: advance the model with the inputs as driven, then compare all outputs.
    task automatic tick();
        logic [3:0]  rg;
        int          ix;
        logic [15:0] rd;
        if (!m_run) begin
            m_din = 16'h0;
            if (load_valid) begin
                m_mem[m_ptr] = load_data;
                if (load_last || m_ptr == DEPTH - 1) m_run = 1;
                else m_ptr++;
            end
        end else begin
            rg = daddr[15:12];
            ix = int'(daddr[6:0]);
            if (rg == 4'h0) begin
                rd = m_mem[ix];
                if (w) m_mem[ix] = dout;
            end else if (rg == 4'h1) begin
                rd = m_leds;
                if (w) m_leds = dout;
            end else if (rg == 4'h2) begin
                rd = m_hex;
                if (w) m_hex = dout;
            end else begin
                rd = 16'h0;
                m_err = 1;
            end
            m_din = rd;
        end
        @(posedge clock); #1;
        chk("din", din, m_din);
        chk("run", 16'(run), 16'(m_run));
        chk("load_ready", 16'(load_ready), 16'(!m_run));
        chk("leds", leds, m_leds);
        chk("hex", hex, m_hex);
        chk("err", 16'(err), 16'(m_err));
    endtask

    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        chk("rst_run", 16'(run), 16'h0);
        chk("rst_leds", leds, 16'h0);
        chk("rst_hex", hex, 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_din", din, 16'h0);
        chk("rst_load_ready", 16'(load_ready), 16'h1);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic bus(input logic wr, input logic [15:0] a, input logic [15:0] d);
        w = wr; daddr = a; dout = d;
        tick();
    endtask

    task automatic load(input logic [15:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic rand_exec(input int n, input bit allow_unm);
        logic [3:0] rg;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, allow_unm ? 4 : 3))
                0, 1:    rg = 4'h0;
                2:       rg = 4'h1;
                3:       rg = 4'h2;
                default: rg = 4'($urandom_range(3, 15));
            endcase
            daddr      = {rg, 12'($urandom)};
            w          = 1'($urandom_range(0, 1));
            dout       = 16'($urandom);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 16'($urandom);
            tick();
        end
        w = 1'b0; load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; daddr = 16'h0; dout = 16'h0; w = 1'b0;
        load_valid = 1'b0; load_data = 16'h0; load_last = 1'b0;
        model_reset();
        #12;
        chk("init_run", 16'(run), 16'h0);
        chk("init_load_ready", 16'(load_ready), 16'h1);
        chk("init_din", din, 16'h0);
        chk("init_leds", leds, 16'h0);
        chk("init_hex", hex, 16'h0);
        chk("init_err", 16'(err), 16'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Idle loader: waits with run low, processor writes ignored.
        w = 1'b1; daddr = 16'h1000; dout = 16'h1234;
        for (int i = 0; i < 4; i++) tick();
        w = 1'b0;

        // Full 128-word stream without load_last.
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (i == 0) first_word = d;
            load(d, 1'b0);
        end
        chk("full_run", 16'(run), 16'h1);
        chk("full_load_ready", 16'(load_ready), 16'h0);
        load(16'hFFFF, 1'b0);
        bus(1'b0, 16'h0000, 16'h0);
        chk("no_129th_write", din, first_word);
        rand_exec(150, 1'b0);

        async_reset();
        load(16'h1111, 1'b0);
        load(16'h2222, 1'b0);
        chk("load_run_low", 16'(run), 16'h0);
        load(16'h3333, 1'b1);
        chk("load_run_high", 16'(run), 16'h1);
        bus(1'b0, 16'h0000, 16'h0); chk("rd0", din, 16'h1111);
        bus(1'b0, 16'h0001, 16'h0); chk("rd1", din, 16'h2222);
        bus(1'b0, 16'h0002, 16'h0); chk("rd2", din, 16'h3333);

        bus(1'b1, 16'h1000, 16'hBEEF); chk("led_wr", leds, 16'hBEEF);
        bus(1'b0, 16'h2005, 16'h5555); chk("hex_rd", din, 16'h0000);
        chk("hex_zero", hex, 16'h0000);
        bus(1'b1, 16'h2000, 16'h00A5); chk("hex_wr", hex, 16'h00A5);

        bus(1'b1, 16'h0005, 16'h0005);
        bus(1'b1, 16'h0005, 16'h0055); chk("rdw_old", din, 16'h0005);
        bus(1'b0, 16'h0005, 16'h0);    chk("rdw_new", din, 16'h0055);
        bus(1'b0, 16'h0085, 16'h0);    chk("alias", din, 16'h0055);

        chk("err_clear", 16'(err), 16'h0);
        bus(1'b1, 16'h7000, 16'h1234); chk("err_set", 16'(err), 16'h1);
        chk("unm_leds", leds, 16'hBEEF);
        chk("unm_hex", hex, 16'h00A5);
        bus(1'b0, 16'h0005, 16'h0);    chk("unm_ram", din, 16'h0055);
        bus(1'b0, 16'hF000, 16'h0);    chk("unm_rd", din, 16'h0000);
        chk("err_sticky", 16'(err), 16'h1);

        rand_exec(200, 1'b1);

        bus(1'b1, 16'h1000, 16'hBEEF);
        pre_word = m_mem[1];
        async_reset();
        load(16'hAAAA, 1'b1);
        bus(1'b0, 16'h0000, 16'h0); chk("reload0", din, 16'hAAAA);
        bus(1'b0, 16'h0001, 16'h0); chk("reload_keep1", din, pre_word);

        // Reset in the middle of a load restarts the pointer at 0.
        async_reset();
        load(16'hC0DE, 1'b0);
        load(16'hFACE, 1'b0);
        async_reset();
        load(16'h5A5A, 1'b1);
        bus(1'b0, 16'h0000, 16'h0); chk("midload0", din, 16'h5A5A);
        bus(1'b0, 16'h0001, 16'h0); chk("midload1", din, 16'hFACE);
        rand_exec(50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
